// File: rtl/riscv_core_pkg.sv
// rtl/riscv_core_pkg.sv - shared opcodes, function codes and control enums for the RV64I core
package riscv_core_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_OR, ALU_AND, ALU_SRL, ALU_SRA, ALU_PASS_B
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  // alt selects SUB/SRA; callers only raise it where that encoding is legal
  function automatic alu_op_e alu_op_from(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD_SUB: return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     return ALU_SLL;
      F3_SLT:     return ALU_SLT;
      F3_SLTU:    return ALU_SLTU;
      F3_XOR:     return ALU_XOR;
      F3_SR:      return alt ? ALU_SRA : ALU_SRL;
      F3_OR:      return ALU_OR;
      default:    return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/riscv_core_alu.sv
// rtl/riscv_core_alu.sv - 64-bit integer ALU with 32-bit word mode sign-extending its result
module riscv_core_alu
  import riscv_core_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  input  logic            word,
  output logic [XLEN-1:0] y
);
  logic [XLEN-1:0] full;
  logic [31:0]     w;

  // full-width result plus the word-mode variant; word shifts use a 5-bit amount
  always_comb begin
    case (op)
      ALU_ADD:    full = a + b;
      ALU_SUB:    full = a - b;
      ALU_SLL:    full = a << b[5:0];
      ALU_SLT:    full = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:   full = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:    full = a ^ b;
      ALU_OR:     full = a | b;
      ALU_AND:    full = a & b;
      ALU_SRL:    full = a >> b[5:0];
      ALU_SRA:    full = $signed(a) >>> b[5:0];
      ALU_PASS_B: full = b;
      default:    full = '0;
    endcase
    case (op)
      ALU_ADD: w = a[31:0] + b[31:0];
      ALU_SUB: w = a[31:0] - b[31:0];
      ALU_SLL: w = a[31:0] << b[4:0];
      ALU_SRL: w = a[31:0] >> b[4:0];
      ALU_SRA: w = $signed(a[31:0]) >>> b[4:0];
      default: w = full[31:0];
    endcase
    y = word ? {{(XLEN-32){w[31]}}, w} : full;
  end
endmodule

// File: rtl/riscv_core_data_mem.sv
// rtl/riscv_core_data_mem.sv - byte-wide data memory, 8-byte combinational read, 1/2/4/8-byte write
module riscv_core_data_mem #(
  parameter int XLEN       = 64,
  parameter int DMEM_BYTES = 1024
) (
  input  logic            clk,
  input  logic            we,
  input  logic [1:0]      size,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);
  localparam int AW = $clog2(DMEM_BYTES);

  logic [7:0] mem [DMEM_BYTES];
  logic [3:0] nbytes;

  function automatic logic [AW-1:0] byte_idx(input logic [XLEN-1:0] base, input int k);
    return AW'((base + XLEN'(k)) % XLEN'(DMEM_BYTES));
  endfunction

  assign nbytes = 4'd1 << size;

  // every byte is addressed on its own, so misaligned accesses simply wrap
  always_comb begin
    rdata = '0;
    for (int k = 0; k < 8; k++) rdata[8*k +: 8] = mem[byte_idx(addr, k)];
  end

  // commit only the low nbytes of the store data; other bytes keep their value
  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (we && (4'(k) < nbytes)) mem[byte_idx(addr, k)] <= wdata[8*k +: 8];
    end
  end
endmodule

// File: rtl/riscv_core_imem.sv
// rtl/riscv_core_imem.sv - byte-wide instruction memory with combinational 32-bit fetch
module riscv_core_imem #(
  parameter int XLEN       = 64,
  parameter int IMEM_BYTES = 1024
) (
  input  logic            clk,
  input  logic            we,
  input  logic [XLEN-1:0] waddr,
  input  logic [7:0]      wdata,
  input  logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);
  localparam int AW = $clog2(IMEM_BYTES);

  logic [7:0] mem [IMEM_BYTES];

  function automatic logic [AW-1:0] byte_idx(input logic [XLEN-1:0] base, input int k);
    return AW'((base + XLEN'(k)) % XLEN'(IMEM_BYTES));
  endfunction

  // little-endian fetch, wrapping at the end of the array
  always_comb begin
    instr = '0;
    for (int k = 0; k < 4; k++) instr[8*k +: 8] = mem[byte_idx(pc, k)];
  end

  // optional single-byte load port; the core ties it off
  always_ff @(posedge clk) begin
    if (we) mem[byte_idx(waddr, 0)] <= wdata;
  end
endmodule

// File: rtl/riscv_core_rf.sv
// rtl/riscv_core_rf.sv - integer register file, two combinational reads, x0 hardwired to zero
module riscv_core_rf #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  input  logic [$clog2(NREGS)-1:0] raddr2,
  output logic [XLEN-1:0]          rdata1,
  output logic [XLEN-1:0]          rdata2
);
  logic [XLEN-1:0] rf [NREGS];

  assign rdata1 = (raddr1 == '0) ? '0 : rf[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : rf[raddr2];

  // x0 writes are dropped so its storage never matters
  always_ff @(posedge clk) begin
    if (we && (waddr != '0)) rf[waddr] <= wdata;
  end
endmodule

// File: rtl/riscv_core_top.sv
// rtl/riscv_core_top.sv - single-cycle RV64I core: fetch, decode, execute, memory and writeback
module riscv_core_top
  import riscv_core_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int IMEM_BYTES = 1024,
  parameter int DMEM_BYTES = 1024,
  parameter int NREGS      = 32
) (
  input logic clk,
  input logic rst
);
  logic [XLEN-1:0] pc, next_pc, pc_plus4, imm;
  logic [XLEN-1:0] rs1_data, rs2_data, alu_a, alu_b, alu_y;
  logic [XLEN-1:0] dmem_rdata, load_data, rd_wdata;
  logic [31:0]     instr;
  logic [6:0]      opcode, funct7;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  imm_type_e       imm_type;
  alu_op_e         alu_op;
  wb_sel_e         wb_sel;
  logic            alu_word, a_pc, b_imm, rf_we, mem_we;
  logic            is_branch, is_jal, is_jalr, br_taken;

  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign funct7   = instr[31:25];
  assign pc_plus4 = pc + XLEN'(4);

  riscv_core_imem #(.XLEN(XLEN), .IMEM_BYTES(IMEM_BYTES)) u_riscv_core_imem (
    .clk(clk), .we(1'b0), .waddr('0), .wdata(8'h00), .pc(pc), .instr(instr)
  );

  riscv_core_rf #(.XLEN(XLEN), .NREGS(NREGS)) u_riscv_core_rf (
    .clk(clk), .we(rf_we && !rst), .waddr(rd), .wdata(rd_wdata),
    .raddr1(rs1), .raddr2(rs2), .rdata1(rs1_data), .rdata2(rs2_data)
  );

  riscv_core_alu #(.XLEN(XLEN)) u_riscv_core_alu (
    .a(alu_a), .b(alu_b), .op(alu_op), .word(alu_word), .y(alu_y)
  );

  riscv_core_data_mem #(.XLEN(XLEN), .DMEM_BYTES(DMEM_BYTES)) u_riscv_core_data_mem (
    .clk(clk), .we(mem_we && !rst), .size(funct3[1:0]), .addr(alu_y),
    .wdata(rs2_data), .rdata(dmem_rdata)
  );

  // decode: anything not recognised leaves every write enable low and falls through to pc+4
  always_comb begin
    imm_type  = IMM_I;
    alu_op    = ALU_ADD;
    alu_word  = 1'b0;
    a_pc      = 1'b0;
    b_imm     = 1'b1;
    rf_we     = 1'b0;
    mem_we    = 1'b0;
    wb_sel    = WB_ALU;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OPC_LUI: begin
        imm_type = IMM_U; alu_op = ALU_PASS_B; rf_we = 1'b1;
      end
      OPC_AUIPC: begin
        imm_type = IMM_U; a_pc = 1'b1; rf_we = 1'b1;
      end
      OPC_JAL: begin
        imm_type = IMM_J; is_jal = 1'b1; rf_we = 1'b1; wb_sel = WB_PC4;
      end
      OPC_JALR: begin
        is_jalr = (funct3 == 3'b000); rf_we = is_jalr; wb_sel = WB_PC4;
      end
      OPC_BRANCH: begin
        imm_type  = IMM_B;
        is_branch = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OPC_LOAD: begin
        rf_we = (funct3 != 3'b111); wb_sel = WB_MEM;
      end
      OPC_STORE: begin
        imm_type = IMM_S; mem_we = !funct3[2];
      end
      OPC_OP_IMM: begin
        alu_op = alu_op_from(funct3, (funct3 == F3_SR) && instr[30]);
        rf_we  = (funct3 == F3_SLL) ? (funct7[6:1] == 6'b000000) :
                 (funct3 == F3_SR)  ? (funct7[6:1] == 6'b000000 || funct7[6:1] == 6'b010000) :
                 1'b1;
      end
      OPC_OP: begin
        b_imm  = 1'b0;
        alu_op = alu_op_from(funct3, instr[30]);
        rf_we  = (funct7 == F7_BASE) ||
                 ((funct7 == F7_ALT) && (funct3 == F3_ADD_SUB || funct3 == F3_SR));
      end
      OPC_OP_IMM_32: begin
        alu_word = 1'b1;
        alu_op   = alu_op_from(funct3, (funct3 == F3_SR) && instr[30]);
        rf_we    = (funct3 == F3_ADD_SUB) ? 1'b1 :
                   (funct3 == F3_SLL)     ? (funct7 == F7_BASE) :
                   (funct3 == F3_SR)      ? (funct7 == F7_BASE || funct7 == F7_ALT) :
                   1'b0;
      end
      OPC_OP_32: begin
        b_imm    = 1'b0;
        alu_word = 1'b1;
        alu_op   = alu_op_from(funct3, instr[30]);
        rf_we    = (funct3 == F3_ADD_SUB || funct3 == F3_SR) ? (funct7 == F7_BASE || funct7 == F7_ALT) :
                   (funct3 == F3_SLL) ? (funct7 == F7_BASE) :
                   1'b0;
      end
      default: ;
    endcase
  end

  // immediate assembly, always sign-extended from instruction bit 31
  always_comb begin
    case (imm_type)
      IMM_S:   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'h000};
      IMM_J:   imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
    endcase
  end

  assign alu_a = a_pc ? pc : rs1_data;
  assign alu_b = b_imm ? imm : rs2_data;

  // branch condition evaluated directly on the register operands
  always_comb begin
    case (funct3)
      F3_BEQ:  br_taken = (rs1_data == rs2_data);
      F3_BNE:  br_taken = (rs1_data != rs2_data);
      F3_BLT:  br_taken = ($signed(rs1_data) < $signed(rs2_data));
      F3_BGE:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: br_taken = (rs1_data < rs2_data);
      F3_BGEU: br_taken = (rs1_data >= rs2_data);
      default: br_taken = 1'b0;
    endcase
  end

  // load extension; the ALU output doubles as the data address
  always_comb begin
    case (funct3)
      F3_LB:   load_data = {{(XLEN-8){dmem_rdata[7]}}, dmem_rdata[7:0]};
      F3_LH:   load_data = {{(XLEN-16){dmem_rdata[15]}}, dmem_rdata[15:0]};
      F3_LW:   load_data = {{(XLEN-32){dmem_rdata[31]}}, dmem_rdata[31:0]};
      F3_LD:   load_data = dmem_rdata;
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, dmem_rdata[7:0]};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, dmem_rdata[15:0]};
      F3_LWU:  load_data = {{(XLEN-32){1'b0}}, dmem_rdata[31:0]};
      default: load_data = '0;
    endcase
  end

  // writeback source and next PC selection
  always_comb begin
    case (wb_sel)
      WB_MEM:  rd_wdata = load_data;
      WB_PC4:  rd_wdata = pc_plus4;
      default: rd_wdata = alu_y;
    endcase
    if (is_jal)                      next_pc = pc + imm;
    else if (is_jalr)                next_pc = {alu_y[XLEN-1:1], 1'b0};
    else if (is_branch && br_taken)  next_pc = pc + imm;
    else                             next_pc = pc_plus4;
  end

  // program counter, forced to zero for as long as reset is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else     pc <= next_pc;
  end
endmodule

// File: tb/tb_riscv_core_top.sv
// tb/tb_riscv_core_top.sv - directed bench for riscv_core_top
module tb_riscv_core_top;
  import riscv_core_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  riscv_core_top dut (.clk(clk), .rst(rst));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    logic [11:0] im = 12'(imm);
    return {im, 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, int rs2, int rs1, int f3, int rd, logic [6:0] op);
    return {f7, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    logic [11:0] im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], OPC_STORE};
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [12:0] im = 13'(imm);
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [20:0] im = 21'(imm);
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), OPC_JAL};
  endfunction

  function automatic logic [31:0] enc_u(logic [19:0] imm, int rd, logic [6:0] op);
    return {imm, 5'(rd), op};
  endfunction

  function automatic logic [63:0] dmem64(int a);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = dut.u_riscv_core_data_mem.mem[a + k];
    return v;
  endfunction

  task automatic load_word(input int addr, input logic [31:0] w);
    for (int k = 0; k < 4; k++) dut.u_riscv_core_imem.mem[addr + k] = w[8*k +: 8];
  endtask

  // called one time unit after a rising edge (or at time 0); leaves reset low before the next edge
  task automatic init_state();
    for (int i = 0; i < 32; i++) dut.u_riscv_core_rf.rf[i] = 64'(2 * i);
    for (int i = 0; i < 1024; i++) dut.u_riscv_core_data_mem.mem[i] = 8'(i);
    for (int i = 0; i < 1024; i += 4) load_word(i, 32'h00000013);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state and backdoor persistence
    init_state();
    check("reset_pc", dut.pc, 64'd0);
    check("rf_persist", dut.u_riscv_core_rf.rf[5], 64'd10);
    step(1);

    // sb x17,32(x0)
    init_state();
    load_word(0, enc_s(32, 17, 0, 0));
    step(1);
    check("sb_byte", 64'(dut.u_riscv_core_data_mem.mem[32]), 64'h22);
    check("sb_next_untouched", 64'(dut.u_riscv_core_data_mem.mem[33]), 64'd33);
    check("sb_pc", dut.pc, 64'd4);

    // sh x17,32(x0)
    init_state();
    load_word(0, enc_s(32, 17, 0, 1));
    step(1);
    check("sh_half", dmem64(32) & 64'hFFFF, 64'h0022);
    check("sh_next_untouched", 64'(dut.u_riscv_core_data_mem.mem[34]), 64'd34);

    // sw x17,32(x0)
    init_state();
    load_word(0, enc_s(32, 17, 0, 2));
    step(1);
    check("sw_word", dmem64(32) & 64'hFFFF_FFFF, 64'h0000_0022);
    check("sw_next_untouched", 64'(dut.u_riscv_core_data_mem.mem[36]), 64'd36);

    // sd x20,16(x8): address 32, data 40
    init_state();
    load_word(0, enc_s(16, 20, 8, 3));
    step(1);
    check("sd_dword", dmem64(32), 64'h0000_0000_0000_0028);
    check("sd_next_untouched", 64'(dut.u_riscv_core_data_mem.mem[40]), 64'd40);

    // ld x5,0(x0)
    init_state();
    load_word(0, enc_i(0, 0, 3, 5, OPC_LOAD));
    step(1);
    check("ld", dut.u_riscv_core_rf.rf[5], 64'h0706_0504_0302_0100);

    // lb x6,0(x7) with mem[14]=0x80, then lhu x9,14(x0)
    init_state();
    dut.u_riscv_core_data_mem.mem[14] = 8'h80;
    load_word(0, enc_i(0, 7, 0, 6, OPC_LOAD));
    load_word(4, enc_i(14, 0, 5, 9, OPC_LOAD));
    step(2);
    check("lb_sext", dut.u_riscv_core_rf.rf[6], 64'hFFFF_FFFF_FFFF_FF80);
    check("lhu_zext", dut.u_riscv_core_rf.rf[9], 64'h0000_0000_0000_0F80);

    // add x17,x1,x2 then subw x3,x1,x2
    init_state();
    load_word(0, enc_r(F7_BASE, 2, 1, 0, 17, OPC_OP));
    load_word(4, enc_r(F7_ALT, 2, 1, 0, 3, OPC_OP_32));
    step(2);
    check("add", dut.u_riscv_core_rf.rf[17], 64'd6);
    check("subw", dut.u_riscv_core_rf.rf[3], 64'hFFFF_FFFF_FFFF_FFFE);

    // addi x0,x1,5 then add x10,x0,x1
    init_state();
    load_word(0, enc_i(5, 1, 0, 0, OPC_OP_IMM));
    load_word(4, enc_r(F7_BASE, 1, 0, 0, 10, OPC_OP));
    step(2);
    check("x0_write_dropped", dut.u_riscv_core_rf.rf[0], 64'd0);
    check("x0_reads_zero", dut.u_riscv_core_rf.rf[10], 64'd2);

    // beq x1,x1,+8 skips addi x11 at pc 4
    init_state();
    load_word(0, enc_b(8, 1, 1, 0));
    load_word(4, enc_i(99, 0, 0, 11, OPC_OP_IMM));
    load_word(8, enc_i(77, 0, 0, 12, OPC_OP_IMM));
    step(2);
    check("beq_pc", dut.pc, 64'd12);
    check("beq_skipped", dut.u_riscv_core_rf.rf[11], 64'd22);
    check("beq_target_ran", dut.u_riscv_core_rf.rf[12], 64'd77);

    // fence and ecall as nops, then jal x1,+12 at pc 8
    init_state();
    load_word(0, 32'h0000_000F);
    load_word(4, 32'h0000_0073);
    load_word(8, enc_j(12, 1));
    step(3);
    check("jal_link", dut.u_riscv_core_rf.rf[1], 64'd12);
    check("jal_pc", dut.pc, 64'd20);

    // lui / srai / srliw / sltu
    init_state();
    load_word(0, enc_u(20'h80000, 15, OPC_LUI));
    load_word(4, enc_i(12'h404, 15, 5, 16, OPC_OP_IMM));
    load_word(8, enc_i(4, 15, 5, 18, OPC_OP_IMM_32));
    load_word(12, enc_r(F7_BASE, 15, 1, 3, 19, OPC_OP));
    step(4);
    check("lui", dut.u_riscv_core_rf.rf[15], 64'hFFFF_FFFF_8000_0000);
    check("srai", dut.u_riscv_core_rf.rf[16], 64'hFFFF_FFFF_F800_0000);
    check("srliw", dut.u_riscv_core_rf.rf[18], 64'h0000_0000_0800_0000);
    check("sltu", dut.u_riscv_core_rf.rf[19], 64'd1);

    // reset asserted mid-program
    init_state();
    load_word(0, enc_i(123, 0, 0, 13, OPC_OP_IMM));
    load_word(4, enc_s(48, 13, 0, 0));
    load_word(8, enc_i(7, 0, 0, 14, OPC_OP_IMM));
    step(2);
    check("pre_reset_pc", dut.pc, 64'd8);
    rst = 1'b1;
    #1;
    check("async_reset_pc", dut.pc, 64'd0);
    check("reset_keeps_rf", dut.u_riscv_core_rf.rf[13], 64'd123);
    check("reset_keeps_dmem", 64'(dut.u_riscv_core_data_mem.mem[48]), 64'd123);
    @(posedge clk);
    #1;
    check("pc_held_in_reset", dut.pc, 64'd0);
    rst = 1'b0;
    step(3);
    check("rerun_pc", dut.pc, 64'd12);
    check("rerun_rf", dut.u_riscv_core_rf.rf[14], 64'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
